// File: rtl/dac_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_stream_tx
// Purpose  : Four-channel parallel-in / serial-out bitstream transmitter for
//            sigma-delta DAC pins. One word set per channel is taken through a
//            valid/ready handshake into a holding register. At every frame
//            boundary the held words move into shift registers. They are then
//            shifted out LSB-first, one bit per clock. When no word set is
//            waiting, a midscale idle pattern is sent instead. The frame and
//            bit order match the four-channel ADC bitstream receive buffer.
//
// Ports    : dac_clk_i       in   bit clock, all logic on the rising edge
//            reset           in   asynchronous reset, active low
//            word_valid_i    in   producer presents a word set
//            word_ready_o    out  holding register empty, a set can be taken
//            dac_[a..d]_word_i in WIDTH-bit word for channel A..D
//            dac_[a..d]_o    out  serial bitstream for channel A..D
//            frame_sync_o    out  high while bit 0 of a frame is on the pins
//            underrun_o      out  sticky flag: a running stream ran dry
//            underrun_clr_i  in   clears underrun_o (a new underrun wins)
//
// Revision : 1.0 - initial release
// ============================================================================
module dac_stream_tx #(
    parameter int unsigned WIDTH        = 32,
    parameter logic [31:0] IDLE_PATTERN = 32'hAAAA_AAAA
) (
    input  logic             dac_clk_i,
    input  logic             reset,
    input  logic             word_valid_i,
    output logic             word_ready_o,
    input  logic [WIDTH-1:0] dac_a_word_i,
    input  logic [WIDTH-1:0] dac_b_word_i,
    input  logic [WIDTH-1:0] dac_c_word_i,
    input  logic [WIDTH-1:0] dac_d_word_i,
    output logic             dac_a_o,
    output logic             dac_b_o,
    output logic             dac_c_o,
    output logic             dac_d_o,
    output logic             frame_sync_o,
    output logic             underrun_o,
    input  logic             underrun_clr_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned           c_num_ch   = 4;
    localparam int unsigned           c_ctr_w    = $clog2(WIDTH);
    localparam logic [c_ctr_w-1:0]    c_ctr_last = c_ctr_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0]      c_idle_word = IDLE_PATTERN[WIDTH-1:0];

    // Stream state. RUN means the frame now being shifted out carries
    // producer data. UNDERRUN means a running stream has fallen back to idle.
    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_run      = 2'd1;
    localparam logic [1:0] c_st_underrun = 2'd2;

    // Width sanity check. The counter wraps naturally only for powers of two,
    // and the idle pattern supplies at most 32 bits.
    if (WIDTH < 8 || WIDTH > 32 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("dac_stream_tx: WIDTH must be a power of 2 in the range 8..32");
    end

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [c_ctr_w-1:0]               r_ctr;
    logic                             r_hold_full;
    logic [1:0]                       r_state;
    logic [1:0]                       w_state_nxt;
    logic                             r_underrun;
    logic                             w_underrun_set;
    logic                             w_boundary;
    logic                             w_accept;
    logic [c_num_ch-1:0][WIDTH-1:0]   w_word_in;
    logic [c_num_ch-1:0]              w_serial;

    // Channel order in the packed array: index 0 = A ... index 3 = D.
    assign w_word_in = {dac_d_word_i, dac_c_word_i, dac_b_word_i, dac_a_word_i};

    // The boundary cycle is the last bit of a frame. The load on its closing
    // edge makes the new bit 0 visible while the counter reads zero.
    assign w_boundary = (r_ctr == c_ctr_last);

    // No bypass: a word set taken on the boundary edge waits in the holding
    // register for the next boundary. This keeps the output timing fixed.
    assign w_accept = word_valid_i & ~r_hold_full;

    // ------------------------------------------------------------------------
    // Bit counter: free-running, wraps at WIDTH (power of two)
    // ------------------------------------------------------------------------
    always_ff @(posedge dac_clk_i or negedge reset) begin
        if (!reset) begin
            r_ctr <= '0;
        end else begin
            r_ctr <= r_ctr + c_ctr_w'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Holding-register occupancy
    // A set can be accepted only while the register is empty, and it is
    // drained only while full. The two updates can never collide.
    // ------------------------------------------------------------------------
    always_ff @(posedge dac_clk_i or negedge reset) begin
        if (!reset) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
        end else if (w_boundary && r_hold_full) begin
            r_hold_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel holding and shift registers
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < c_num_ch; gi++) begin : g_ch
        logic [WIDTH-1:0] r_hold;
        logic [WIDTH-1:0] r_shift;

        always_ff @(posedge dac_clk_i or negedge reset) begin
            if (!reset) begin
                r_hold <= '0;
            end else if (w_accept) begin
                r_hold <= w_word_in[gi];
            end
        end

        // The boundary load uses r_hold_full as it was before this edge, so a
        // set accepted on the same edge is not picked up.
        always_ff @(posedge dac_clk_i or negedge reset) begin
            if (!reset) begin
                r_shift <= c_idle_word;
            end else if (w_boundary) begin
                r_shift <= r_hold_full ? r_hold : c_idle_word;
            end else begin
                r_shift <= r_shift >> 1;
            end
        end

        assign w_serial[gi] = r_shift[0];
    end

    // ------------------------------------------------------------------------
    // Stream state machine. It changes only on the boundary edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_underrun_set = 1'b0;
        if (w_boundary) begin
            case (r_state)
                c_st_idle: begin
                    if (r_hold_full) begin
                        w_state_nxt = c_st_run;
                    end
                end
                c_st_run: begin
                    if (!r_hold_full) begin
                        w_state_nxt    = c_st_underrun;
                        w_underrun_set = 1'b1;
                    end
                end
                c_st_underrun: begin
                    if (r_hold_full) begin
                        w_state_nxt = c_st_run;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge dac_clk_i or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky underrun flag. A new underrun overrides a clear on the same edge,
    // so no event is lost.
    // ------------------------------------------------------------------------
    always_ff @(posedge dac_clk_i or negedge reset) begin
        if (!reset) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr_i) begin
            r_underrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign word_ready_o = ~r_hold_full;
    assign frame_sync_o = (r_ctr == '0);
    assign underrun_o   = r_underrun;
    assign dac_a_o      = w_serial[0];
    assign dac_b_o      = w_serial[1];
    assign dac_c_o      = w_serial[2];
    assign dac_d_o      = w_serial[3];

endmodule
`default_nettype wire

// File: tb/tb_dac_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_stream_tx
// Purpose  : Self-checking bench for dac_stream_tx. A frame-level reference
//            model keeps a queue of accepted word sets and the word now being
//            sent, and indexes bits by frame position. A receive-side frame
//            collector rebuilds words from the serial pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_stream_tx;

    localparam int          WIDTH = 32;
    localparam logic [31:0] IDLE  = 32'hAAAA_AAAA;
    localparam logic [4*WIDTH-1:0] IDLE4 = {4{IDLE}};

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             valid = 1'b0;
    logic             clr   = 1'b0;
    logic [WIDTH-1:0] wa = '0, wb = '0, wc = '0, wd = '0;
    logic             ready, da, db, dc, dd, sync, ur;

    int n_cmp = 0;
    int n_bad = 0;

    dac_stream_tx #(
        .WIDTH        (WIDTH),
        .IDLE_PATTERN (IDLE)
    ) dut (
        .dac_clk_i      (clk),
        .reset          (reset),
        .word_valid_i   (valid),
        .word_ready_o   (ready),
        .dac_a_word_i   (wa),
        .dac_b_word_i   (wb),
        .dac_c_word_i   (wc),
        .dac_d_word_i   (wd),
        .dac_a_o        (da),
        .dac_b_o        (db),
        .dac_c_o        (dc),
        .dac_d_o        (dd),
        .frame_sync_o   (sync),
        .underrun_o     (ur),
        .underrun_clr_i (clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (word sets packed {D,C,B,A}) ----------
    int                 m_pos;
    logic [4*WIDTH-1:0] m_cur;
    logic [4*WIDTH-1:0] m_hold_q[$];
    bit                 m_prev_data;
    bit                 m_ur;

    task automatic model_reset();
        m_pos       = 0;
        m_cur       = IDLE4;
        m_hold_q.delete();
        m_prev_data = 1'b0;
        m_ur        = 1'b0;
    endtask

    // One clock edge. The model is updated from the inputs in force at the
    // edge, and the task returns 1 time unit later, where outputs are sampled.
    task automatic tick();
        bit bnd, empty, set_ur;
        @(posedge clk);
        bnd    = (m_pos == WIDTH - 1);
        empty  = (m_hold_q.size() == 0);
        set_ur = 1'b0;
        if (bnd) begin
            if (!empty) begin
                m_cur       = m_hold_q.pop_front();
                m_prev_data = 1'b1;
            end else begin
                m_cur       = IDLE4;
                set_ur      = m_prev_data;   // running stream ran dry
                m_prev_data = 1'b0;
            end
        end
        if (valid && empty) m_hold_q.push_back({wd, wc, wb, wa});
        if (set_ur) m_ur = 1'b1;
        else if (clr) m_ur = 1'b0;
        m_pos = (m_pos + 1) % WIDTH;
        #1;
    endtask

    task automatic next_pos(input int p);
        tick();
        for (int i = 0; i < WIDTH && m_pos != p; i++) tick();
    endtask

    task automatic drive(input bit v, input logic [4*WIDTH-1:0] w);
        valid = v;
        {wd, wc, wb, wa} = w;
    endtask

    function automatic logic [4*WIDTH-1:0] rand_set();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- receive-side frame collector ---------------------------
    logic [4*WIDTH-1:0] rx_q[$];
    logic [4*WIDTH-1:0] rx_frame;
    int                 rx_idx = -1;

    always @(negedge clk) begin
        if (sync) rx_idx = 0;
        if (rx_idx >= 0) begin
            rx_frame[rx_idx]           = da;
            rx_frame[WIDTH + rx_idx]   = db;
            rx_frame[2*WIDTH + rx_idx] = dc;
            rx_frame[3*WIDTH + rx_idx] = dd;
            if (rx_idx == WIDTH - 1) begin
                rx_q.push_back(rx_frame);
                rx_idx = -1;
            end else begin
                rx_idx++;
            end
        end
    end

    // Reset pulse that lies wholly between two clock edges.
    task automatic apply_reset();
        drive(1'b0, '0);
        clr   = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
        rx_q.delete();
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        #2;
        n_cmp++;
        if ({da, db, dc, dd, sync, ready, ur} !== 7'b0000_110) begin
            n_bad++;
            $display("FAIL por_outputs: got %b expected %b", {da, db, dc, dd, sync, ready, ur}, 7'b0000_110);
        end
        reset = 1'b1;
        for (int i = 1; i <= WIDTH; i++) begin
            tick();
            n_cmp++;
            if (sync !== (i % WIDTH == 0)) begin
                n_bad++;
                $display("FAIL frame_sync_cycle%0d: got %b expected %b", i, sync, (i % WIDTH == 0));
            end
        end
        // Build up mid-frame state: all-ones frame on the pins, another set held.
        next_pos(2);
        drive(1'b1, {4*WIDTH{1'b1}});
        tick();
        drive(1'b0, '0);
        next_pos(0);
        next_pos(5);
        drive(1'b1, rand_set());
        tick();
        drive(1'b0, '0);
        next_pos(13);
        n_cmp++;
        if ({da, db, dc, dd, ready} !== 5'b1111_0) begin
            n_bad++;
            $display("FAIL pre_reset_state: got %b expected %b", {da, db, dc, dd, ready}, 5'b1111_0);
        end
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({da, db, dc, dd, sync, ready, ur} !== 7'b0000_110) begin
            n_bad++;
            $display("FAIL midframe_reset: got %b expected %b", {da, db, dc, dd, sync, ready, ur}, 7'b0000_110);
        end
        reset = 1'b1;
        rx_q.delete();
        tick();
        n_cmp++;
        if ({da, sync, ready} !== {IDLE[1], 2'b01}) begin
            n_bad++;
            $display("FAIL after_reset_cycle1: got %b expected %b", {da, sync, ready}, {IDLE[1], 2'b01});
        end
    endtask

    task automatic test_single_frame();
        logic [4*WIDTH-1:0] f;
        apply_reset();
        next_pos(5);
        drive(1'b1, {32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001});
        tick();
        drive(1'b0, '0);
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_drop: got %b expected 0", ready);
        end
        next_pos(WIDTH - 1);
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_boundary: got %b expected 0", ready);
        end
        tick();
        n_cmp++;
        if ({ready, sync} !== 2'b11) begin
            n_bad++;
            $display("FAIL ready_return: got %b expected 11", {ready, sync});
        end
        for (int i = 0; i < 3*WIDTH && rx_q.size() < 2; i++) tick();
        n_cmp++;
        if (rx_q.size() < 2) begin
            n_bad++;
            $display("FAIL single_timeout: got %0d frames expected 2", rx_q.size());
        end else begin
            f = rx_q[1];
            n_cmp++;
            if (f[WIDTH-1:0] !== 32'h0000_0001) begin
                n_bad++; $display("FAIL single_ch_a: got %h expected 00000001", f[WIDTH-1:0]);
            end
            n_cmp++;
            if (f[2*WIDTH-1:WIDTH] !== 32'h8000_0000) begin
                n_bad++; $display("FAIL single_ch_b: got %h expected 80000000", f[2*WIDTH-1:WIDTH]);
            end
            n_cmp++;
            if (f[3*WIDTH-1:2*WIDTH] !== 32'hFFFF_FFFF) begin
                n_bad++; $display("FAIL single_ch_c: got %h expected ffffffff", f[3*WIDTH-1:2*WIDTH]);
            end
            n_cmp++;
            if (f[4*WIDTH-1:3*WIDTH] !== 32'h1234_5678) begin
                n_bad++; $display("FAIL single_ch_d: got %h expected 12345678", f[4*WIDTH-1:3*WIDTH]);
            end
        end
    endtask

    task automatic test_loopback();
        logic [4*WIDTH-1:0] sent[$];
        int nsent   = 0;
        bit ur_seen = 1'b0;
        apply_reset();
        for (int i = 0; i < 100; i++) sent.push_back(rand_set());
        for (int cyc = 0; cyc < 102*WIDTH && rx_q.size() < 101; cyc++) begin
            if (ready && nsent < 100) begin
                drive(1'b1, sent[nsent]);
                nsent++;
            end else begin
                drive(1'b0, '0);
            end
            tick();
            if (rx_q.size() < 101 && ur) ur_seen = 1'b1;
        end
        drive(1'b0, '0);
        n_cmp++;
        if (rx_q.size() < 101) begin
            n_bad++;
            $display("FAIL loopback_timeout: got %0d frames expected 101", rx_q.size());
        end else begin
            n_cmp++;
            if (rx_q[0] !== IDLE4) begin
                n_bad++; $display("FAIL loopback_first_idle: got %h expected %h", rx_q[0], IDLE4);
            end
            for (int i = 0; i < 100; i++) begin
                n_cmp++;
                if (rx_q[i+1] !== sent[i]) begin
                    n_bad++; $display("FAIL loopback_word%0d: got %h expected %h", i, rx_q[i+1], sent[i]);
                end
            end
        end
        n_cmp++;
        if (ur_seen !== 1'b0) begin
            n_bad++; $display("FAIL loopback_underrun: got %b expected 0", ur_seen);
        end
    endtask

    task automatic test_underrun();
        logic [4*WIDTH-1:0] w1, w2;
        w1 = rand_set();
        w2 = rand_set();
        apply_reset();
        next_pos(2);
        drive(1'b1, w1);
        tick();
        drive(1'b0, '0);
        next_pos(WIDTH - 1);
        next_pos(WIDTH - 1);
        n_cmp++;
        if (ur !== 1'b0) begin
            n_bad++; $display("FAIL underrun_before: got %b expected 0", ur);
        end
        tick();
        n_cmp++;
        if ({ur, sync} !== 2'b11) begin
            n_bad++; $display("FAIL underrun_rise: got %b expected 11", {ur, sync});
        end
        next_pos(7);
        drive(1'b1, w2);
        tick();
        drive(1'b0, '0);
        next_pos(0);
        n_cmp++;
        if (ur !== 1'b1) begin
            n_bad++; $display("FAIL underrun_sticky: got %b expected 1", ur);
        end
        next_pos(4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (ur !== 1'b0) begin
            n_bad++; $display("FAIL underrun_clear: got %b expected 0", ur);
        end
        for (int i = 0; i < 2*WIDTH && rx_q.size() < 4; i++) tick();
        n_cmp++;
        if (rx_q.size() < 4) begin
            n_bad++; $display("FAIL underrun_timeout: got %0d frames expected 4", rx_q.size());
        end else begin
            n_cmp++;
            if (rx_q[1] !== w1) begin
                n_bad++; $display("FAIL underrun_data1: got %h expected %h", rx_q[1], w1);
            end
            n_cmp++;
            if (rx_q[2] !== IDLE4) begin
                n_bad++; $display("FAIL underrun_idle_frame: got %h expected %h", rx_q[2], IDLE4);
            end
            n_cmp++;
            if (rx_q[3] !== w2) begin
                n_bad++; $display("FAIL underrun_data2: got %h expected %h", rx_q[3], w2);
            end
        end
    endtask

    task automatic test_collisions();
        logic [4*WIDTH-1:0] w1, w2, w3, w4;
        w1 = rand_set(); w2 = rand_set(); w3 = rand_set(); w4 = rand_set();
        apply_reset();
        next_pos(3);
        drive(1'b1, w1);
        tick();
        drive(1'b0, '0);
        next_pos(WIDTH - 1);
        next_pos(WIDTH - 1);
        // Holding empty in RUN: new set and a clear arrive in the boundary cycle.
        drive(1'b1, w2);
        clr = 1'b1;
        tick();
        drive(1'b0, '0);
        clr = 1'b0;
        n_cmp++;
        if ({ur, ready, sync} !== 3'b101) begin
            n_bad++; $display("FAIL collide_set_vs_clear: got %b expected 101", {ur, ready, sync});
        end
        next_pos(0);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++; $display("FAIL collide_ready_frame3: got %b expected 1", ready);
        end
        next_pos(10);
        drive(1'b1, w3);
        tick();
        drive(1'b0, '0);
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++; $display("FAIL collide_hold_full: got %b expected 0", ready);
        end
        // Holding full: valid presented in the boundary cycle and held.
        next_pos(WIDTH - 1);
        drive(1'b1, w4);
        tick();
        n_cmp++;
        if ({ready, sync} !== 2'b11) begin
            n_bad++; $display("FAIL collide_ready_at_ctr0: got %b expected 11", {ready, sync});
        end
        tick();
        drive(1'b0, '0);
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++; $display("FAIL collide_accept_at_ctr0: got %b expected 0", ready);
        end
        for (int i = 0; i < 3*WIDTH && rx_q.size() < 6; i++) tick();
        n_cmp++;
        if (rx_q.size() < 6) begin
            n_bad++; $display("FAIL collide_timeout: got %0d frames expected 6", rx_q.size());
        end else begin
            n_cmp++;
            if (rx_q[1] !== w1) begin
                n_bad++; $display("FAIL collide_f1: got %h expected %h", rx_q[1], w1);
            end
            n_cmp++;
            if (rx_q[2] !== IDLE4) begin
                n_bad++; $display("FAIL collide_f2_idle: got %h expected %h", rx_q[2], IDLE4);
            end
            n_cmp++;
            if (rx_q[3] !== w2) begin
                n_bad++; $display("FAIL collide_f3: got %h expected %h", rx_q[3], w2);
            end
            n_cmp++;
            if (rx_q[4] !== w3) begin
                n_bad++; $display("FAIL collide_f4: got %h expected %h", rx_q[4], w3);
            end
            n_cmp++;
            if (rx_q[5] !== w4) begin
                n_bad++; $display("FAIL collide_f5: got %h expected %h", rx_q[5], w4);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] act, exp;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive($urandom_range(0, 23) == 0, rand_set());
            clr = ($urandom_range(0, 63) == 0);
            tick();
            exp = {m_cur[m_pos], m_cur[WIDTH + m_pos], m_cur[2*WIDTH + m_pos],
                   m_cur[3*WIDTH + m_pos], (m_pos == 0), (m_hold_q.size() == 0), m_ur};
            act = {da, db, dc, dd, sync, ready, ur};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %b expected %b (abcd,sync,ready,underrun)", cyc, act, exp);
            end
        end
        drive(1'b0, '0);
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_loopback();
        test_underrun();
        test_collisions();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
